id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have these ports: clk  input  1  rising-edge clock, the single clock.
REQ-002 rst  input  1  reset, synchronous and active-high.
REQ-003 in_valid  input  1  decoded instruction present; in_ready  output  1  stage can accept it.
REQ-004 opcode  input  7; funct3  input  3; funct7b5  input  1  (instr bit 30).
REQ-005 rs1_idx, rs2_idx, rd_idx  input  5 each; rs1_data, rs2_data, imm, pc  input  32 each.
REQ-006 wb_we  input  1; wb_rd  input  5; wb_data  input  32  writeback bypass bus.
REQ-007 flush  input  1  kill the held entry and any incoming one.
REQ-008 out_valid  output  1; out_ready  input  1  ALU/EX consumer accepts.
REQ-009 alu_a, alu_b  output  32  ALU operands A/B; alu_ctrl  output  4  ALU control code.
REQ-010 rd_out  output  5; reg_write  output  1; mem_read, mem_write  output  1 each; illegal  output  1; store_data  output  32.

Function
REQ-011 Single-entry pipeline register; all outputs driven from registers only.
REQ-012 in_ready = !out_valid || out_ready (combinational); transfer in when in_valid && in_ready.
REQ-013 Out handshake: entry retires when out_valid && out_ready; outputs stable while out_valid && !out_ready.
REQ-014 Capture priority per cycle: rst > flush > accept > retire-only > hold.
REQ-015 flush: out_valid <= 0 next cycle; incoming instruction in same cycle discarded.
REQ-016 Latency: accepted in cycle N -> out_valid in N+1; back-to-back throughput 1/cycle with out_ready=1.
REQ-017 Bypass at capture: operand rsX = wb_data if wb_we && wb_rd!=0 && wb_rd==rsX_idx, else rsX_data.
REQ-018 Hold refresh: each held cycle, register-sourced operands (alu_a/alu_b/store_data) reload wb_data on the same match rule using stored indices; imm/pc/zero operands never refreshed.
REQ-019 Operand select: R-type 0110011: A=rs1, B=rs2; I-ALU 0010011: A=rs1, B=imm; LOAD 0000011: A=rs1, B=imm; STORE 0100011: A=rs1, B=imm, store_data=rs2; LUI 0110111: A=0, B=imm; AUIPC 0010111: A=pc, B=imm.
REQ-020 alu_ctrl by funct3 for R/I-ALU: 000 ADD 0000 (SUB 0001 only R-type with funct7b5=1); 001 SLL 0101; 010 SLT 1000; 011 SLTU 1001; 100 XOR 0010; 101 SRL 0110 or SRA 0111 if funct7b5; 110 OR 0100; 111 AND 0011.
REQ-021 LOAD/STORE/LUI/AUIPC: alu_ctrl=0000.
REQ-022 reg_write=1 for R, I-ALU, LOAD, LUI, AUIPC with rd_idx!=0; 0 otherwise; mem_read=1 LOAD only; mem_write=1 STORE only.
REQ-023 Any other opcode: illegal=1, alu_ctrl=0000, A=B=0, reg_write=mem_read=mem_write=0; entry still flows with out_valid.
REQ-024 store_data=0 for non-STORE; operands use only rs indices the format reads (no bypass match on unused fields).

Reset
REQ-025 On rst high at clk edge: out_valid=0, alu_a=alu_b=store_data=0, alu_ctrl=0000, rd_out=0, reg_write=mem_read=mem_write=illegal=0; in_ready=1 next cycle.
REQ-026 rst mid-hold discards the held entry; no output retained after release.

Verification
REQ-027 R-type SUB, rs1_data=10, rs2_data=3, funct7b5=1, out_ready=1 -> next cycle out_valid=1, alu_a=10, alu_b=3, alu_ctrl=0001, reg_write=1.
REQ-028 I-type SRAI funct3=101 funct7b5=1, imm=4, wb_we=1, wb_rd=rs1_idx=5, wb_data=0xF000_0000 -> alu_a=0xF000_0000, alu_b=4, alu_ctrl=0111.
REQ-029 Bypass to x0: rs1_idx=0, wb_rd=0, wb_we=1, wb_data=0xDEAD -> alu_a=rs1_data (0), not 0xDEAD.
REQ-030 Stall: out_ready=0 for 3 cycles holding R-type rs2_idx=7; wb writes x7=0x55 in cycle 2 -> in_ready=0 throughout, alu_b=0x55 from cycle 3, other outputs unchanged; retire on out_ready=1.
REQ-031 flush with in_valid=1 while entry held -> next cycle out_valid=0, in_ready=1, new instruction not captured.
REQ-032 Unknown opcode 1111111 -> out_valid=1, illegal=1, reg_write=0, alu_ctrl=0000; rst asserted during hold -> out_valid=0 next cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes ALU control, selects operands and
// forwards the writeback bus at capture and while the entry is stalled.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [4:0]  rs1_idx,
    input  logic [4:0]  rs2_idx,
    input  logic [4:0]  rd_idx,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] imm,
    input  logic [31:0] pc,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    output logic [4:0]  rd_out,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        illegal,
    output logic [31:0] store_data
);

    function automatic logic [3:0] alu_fn(input logic [2:0] f3,
                                          input logic f7,
                                          input logic rtype);
        logic [3:0] c;
        case (f3)
            3'b000:  c = (rtype && f7) ? 4'b0001 : 4'b0000;
            3'b001:  c = 4'b0101;
            3'b010:  c = 4'b1000;
            3'b011:  c = 4'b1001;
            3'b100:  c = 4'b0010;
            3'b101:  c = f7 ? 4'b0111 : 4'b0110;
            3'b110:  c = 4'b0100;
            default: c = 4'b0011;
        endcase
        return c;
    endfunction

    function automatic logic hit(input logic we, input logic [4:0] wrd,
                                 input logic [4:0] idx);
        return we && (wrd != 5'd0) && (wrd == idx);
    endfunction

    logic is_r, is_i, is_ld, is_st, is_lui, is_auipc;
    logic [31:0] src1, src2;
    logic [31:0] d_a, d_b, d_sd;
    logic [3:0]  d_ctrl;
    logic        d_rw, d_mr, d_mw, d_ill;
    logic        d_use_a, d_use_b, d_use_sd;

    // Which held operands are register-sourced and eligible for refresh.
    logic        use_a, use_b, use_sd;
    logic [4:0]  rs1_q, rs2_q;

    logic accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    assign is_r     = opcode == 7'b0110011;
    assign is_i     = opcode == 7'b0010011;
    assign is_ld    = opcode == 7'b0000011;
    assign is_st    = opcode == 7'b0100011;
    assign is_lui   = opcode == 7'b0110111;
    assign is_auipc = opcode == 7'b0010111;

    assign src1 = hit(wb_we, wb_rd, rs1_idx) ? wb_data : rs1_data;
    assign src2 = hit(wb_we, wb_rd, rs2_idx) ? wb_data : rs2_data;

    always_comb begin
        d_a      = '0;
        d_b      = '0;
        d_sd     = '0;
        d_ctrl   = 4'b0000;
        d_rw     = 1'b0;
        d_mr     = 1'b0;
        d_mw     = 1'b0;
        d_ill    = 1'b0;
        d_use_a  = 1'b0;
        d_use_b  = 1'b0;
        d_use_sd = 1'b0;
        unique case (1'b1)
            is_r: begin
                d_a     = src1;
                d_b     = src2;
                d_use_a = 1'b1;
                d_use_b = 1'b1;
                d_ctrl  = alu_fn(funct3, funct7b5, 1'b1);
                d_rw    = rd_idx != 5'd0;
            end
            is_i: begin
                d_a     = src1;
                d_b     = imm;
                d_use_a = 1'b1;
                d_ctrl  = alu_fn(funct3, funct7b5, 1'b0);
                d_rw    = rd_idx != 5'd0;
            end
            is_ld: begin
                d_a     = src1;
                d_b     = imm;
                d_use_a = 1'b1;
                d_rw    = rd_idx != 5'd0;
                d_mr    = 1'b1;
            end
            is_st: begin
                d_a      = src1;
                d_b      = imm;
                d_sd     = src2;
                d_use_a  = 1'b1;
                d_use_sd = 1'b1;
                d_mw     = 1'b1;
            end
            is_lui: begin
                d_b  = imm;
                d_rw = rd_idx != 5'd0;
            end
            is_auipc: begin
                d_a  = pc;
                d_b  = imm;
                d_rw = rd_idx != 5'd0;
            end
            default: d_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            store_data <= '0;
            alu_ctrl   <= 4'b0000;
            rd_out     <= '0;
            reg_write  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            illegal    <= 1'b0;
            use_a      <= 1'b0;
            use_b      <= 1'b0;
            use_sd     <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            alu_a      <= d_a;
            alu_b      <= d_b;
            store_data <= d_sd;
            alu_ctrl   <= d_ctrl;
            rd_out     <= rd_idx;
            reg_write  <= d_rw;
            mem_read   <= d_mr;
            mem_write  <= d_mw;
            illegal    <= d_ill;
            use_a      <= d_use_a;
            use_b      <= d_use_b;
            use_sd     <= d_use_sd;
            rs1_q      <= rs1_idx;
            rs2_q      <= rs2_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            if (use_a && hit(wb_we, wb_rd, rs1_q))
                alu_a <= wb_data;
            if (use_b && hit(wb_we, wb_rd, rs2_q))
                alu_b <= wb_data;
            if (use_sd && hit(wb_we, wb_rd, rs2_q))
                store_data <= wb_data;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: retired entries are checked against
// a queue of expected results pushed when each instruction is driven.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rs1_idx, rs2_idx, rd_idx;
    logic [31:0] rs1_data, rs2_data, imm, pc;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush, out_valid, out_ready;
    logic [31:0] alu_a, alu_b, store_data;
    logic [3:0]  alu_ctrl;
    logic [4:0]  rd_out;
    logic        reg_write, mem_read, mem_write, illegal;

    typedef struct {
        logic [31:0] a, b, sd;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic        rw, mr, mw, il;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   retired = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rd_idx(rd_idx),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .rd_out(rd_out), .reg_write(reg_write), .mem_read(mem_read),
        .mem_write(mem_write), .illegal(illegal), .store_data(store_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        tests++;
        assert (got === want)
        else begin
            fails++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic [4:0] r1,
                             input logic [4:0] r2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2,
                             input logic [31:0] im, input logic [31:0] p);
        in_valid = 1'b1;
        opcode = op; funct3 = f3; funct7b5 = f7;
        rs1_idx = r1; rs2_idx = r2; rd_idx = rd;
        rs1_data = d1; rs2_data = d2; imm = im; pc = p;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] c, input logic [31:0] sd,
                        input logic [4:0] rd, input logic rw,
                        input logic mr, input logic mw, input logic il);
        exp_t e;
        e.a = a; e.b = b; e.ctrl = c; e.sd = sd; e.rd = rd;
        e.rw = rw; e.mr = mr; e.mw = mw; e.il = il;
        sb.push_back(e);
    endtask

    // Handshake decided at the next rising edge is stable here.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            tests++;
            assert (sb.size() > 0)
            else begin
                fails++;
                $error("FAIL sb_underflow: got retire want none");
            end
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                retired++;
                chk("ret_a", alu_a, e.a);
                chk("ret_b", alu_b, e.b);
                chk("ret_ctrl", {28'd0, alu_ctrl}, {28'd0, e.ctrl});
                chk("ret_sd", store_data, e.sd);
                chk("ret_rd", {27'd0, rd_out}, {27'd0, e.rd});
                chk("ret_rw", {31'd0, reg_write}, {31'd0, e.rw});
                chk("ret_mr", {31'd0, mem_read}, {31'd0, e.mr});
                chk("ret_mw", {31'd0, mem_write}, {31'd0, e.mw});
                chk("ret_il", {31'd0, illegal}, {31'd0, e.il});
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        set_instr(7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0);
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_ctrl", {28'd0, alu_ctrl}, 0);
        chk("rst_rw", {31'd0, reg_write}, 0);
        chk("rst_il", {31'd0, illegal}, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("rst_ready", {31'd0, in_ready}, 1);

        // SUB
        set_instr(7'b0110011, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3,
                  32'd10, 32'd3, 32'd0, 32'd0);
        push(32'd10, 32'd3, 4'b0001, 0, 5'd3, 1, 0, 0, 0);
        tick();
        chk("lat_valid", {31'd0, out_valid}, 1);
        // SRAI with bypass on rs1
        set_instr(7'b0010011, 3'b101, 1'b1, 5'd5, 5'd5, 5'd6,
                  32'h1234, 32'h9, 32'd4, 32'd0);
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hF000_0000;
        chk("b2b_ready", {31'd0, in_ready}, 1);
        push(32'hF000_0000, 32'd4, 4'b0111, 0, 5'd6, 1, 0, 0, 0);
        tick();
        // ADDI from x0 with a writeback aimed at x0
        set_instr(7'b0010011, 3'b000, 1'b0, 5'd0, 5'd0, 5'd1,
                  32'd0, 32'd0, 32'd7, 32'd0);
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        push(32'd0, 32'd7, 4'b0000, 0, 5'd1, 1, 0, 0, 0);
        tick();
        wb_we = 1'b0;
        // LW
        set_instr(7'b0000011, 3'b010, 1'b0, 5'd2, 5'd0, 5'd4,
                  32'd100, 32'd0, 32'd8, 32'd0);
        push(32'd100, 32'd8, 4'b0000, 0, 5'd4, 1, 1, 0, 0);
        tick();
        // SW with bypass on rs2
        set_instr(7'b0100011, 3'b010, 1'b0, 5'd2, 5'd9, 5'd5,
                  32'd200, 32'hAB, 32'd12, 32'd0);
        wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h77;
        push(32'd200, 32'd12, 4'b0000, 32'h77, 5'd5, 0, 0, 1, 0);
        tick();
        // LUI to x0: operand A is zero, no write
        set_instr(7'b0110111, 3'b000, 1'b0, 5'd9, 5'd9, 5'd0,
                  32'd99, 32'd98, 32'h1234_5000, 32'd0);
        push(32'd0, 32'h1234_5000, 4'b0000, 0, 5'd0, 0, 0, 0, 0);
        tick();
        wb_we = 1'b0;
        // AUIPC
        set_instr(7'b0010111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd7,
                  32'd1, 32'd2, 32'h1000, 32'h400);
        push(32'h400, 32'h1000, 4'b0000, 0, 5'd7, 1, 0, 0, 0);
        tick();
        // ADDI with bit30 set stays ADD
        set_instr(7'b0010011, 3'b000, 1'b1, 5'd3, 5'd0, 5'd8,
                  32'd5, 32'd0, 32'hFFFF_FFFF, 32'd0);
        push(32'd5, 32'hFFFF_FFFF, 4'b0000, 0, 5'd8, 1, 0, 0, 0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("drain_valid", {31'd0, out_valid}, 0);

        // Stall: AND held three cycles, x7 written in the second
        out_ready = 1'b0;
        set_instr(7'b0110011, 3'b111, 1'b0, 5'd6, 5'd7, 5'd10,
                  32'h0F, 32'h11, 32'd0, 32'd0);
        push(32'h0F, 32'h55, 4'b0011, 0, 5'd10, 1, 0, 0, 0);
        tick();
        set_instr(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd1, 5'd11,
                  32'hBAD, 32'hBAD, 32'd0, 32'd0);
        chk("hold1_ready", {31'd0, in_ready}, 0);
        chk("hold1_b", alu_b, 32'h11);
        wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'h55;
        tick();
        wb_we = 1'b0;
        chk("hold2_ready", {31'd0, in_ready}, 0);
        chk("hold2_b", alu_b, 32'h55);
        chk("hold2_a", alu_a, 32'h0F);
        chk("hold2_ctrl", {28'd0, alu_ctrl}, 32'h3);
        chk("hold2_rd", {27'd0, rd_out}, 32'd10);
        tick();
        chk("hold3_ready", {31'd0, in_ready}, 0);
        chk("hold3_b", alu_b, 32'h55);
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("stall_retired", {31'd0, out_valid}, 0);

        // Flush held entry together with an incoming one
        out_ready = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3,
                  32'd1, 32'd2, 32'd0, 32'd0);
        tick();
        chk("fl_held", {31'd0, out_valid}, 1);
        flush = 1'b1;
        set_instr(7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd4,
                  32'd1, 32'd0, 32'd1, 32'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", {31'd0, out_valid}, 0);
        chk("fl_ready", {31'd0, in_ready}, 1);
        out_ready = 1'b1;
        tick();
        chk("fl_nocapture", {31'd0, out_valid}, 0);

        // Illegal opcode held, then reset mid-hold
        out_ready = 1'b0;
        set_instr(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3,
                  32'd1, 32'd2, 32'd3, 32'd4);
        tick();
        in_valid = 1'b0;
        chk("ill_valid", {31'd0, out_valid}, 1);
        chk("ill_flag", {31'd0, illegal}, 1);
        chk("ill_rw", {31'd0, reg_write}, 0);
        chk("ill_ctrl", {28'd0, alu_ctrl}, 0);
        chk("ill_a", alu_a, 0);
        chk("ill_b", alu_b, 0);
        rst = 1'b1;
        tick();
        chk("rst_hold_valid", {31'd0, out_valid}, 0);
        chk("rst_hold_il", {31'd0, illegal}, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_valid", {31'd0, out_valid}, 0);
        chk("post_rst_ready", {31'd0, in_ready}, 1);

        chk("sb_empty", sb.size(), 0);
        chk("retired", retired, 9);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
